// File: rtl/pwm_capture_mc.sv
// pwm_capture_mc: multi-channel PWM width/period capture.
// Each channel synchronises its pin, applies a polarity, and measures the
// active-phase width and full period in timebase pulses. Counters saturate
// rather than wrap, and a saturated measurement is reported with overflow
// set and the raw pin level, so that 0 % and 100 % duty inputs are visible.
module pwm_capture_mc #(
    parameter int K_NCHAN  = 4,
    parameter int K_DWIDTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_timebase,
    input  logic [K_NCHAN-1:0]            i_pwm,
    input  logic [K_NCHAN-1:0]            i_polarity,
    input  logic [K_NCHAN-1:0]            i_enable,
    output logic [K_NCHAN-1:0]            o_capture_start,
    output logic [K_NCHAN-1:0]            o_capture_done,
    output logic [K_NCHAN*K_DWIDTH-1:0]   o_width,
    output logic [K_NCHAN*K_DWIDTH-1:0]   o_period,
    output logic [K_NCHAN-1:0]            o_overflow,
    output logic [K_NCHAN-1:0]            o_level
);

    localparam logic [K_DWIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_ACTIVE,
        ST_INACTIVE
    } state_t;

    for (genvar gi = 0; gi < K_NCHAN; gi++) begin : g_chan
        logic                sync1_reg, sync2_reg, sync_d_reg, pol_reg;
        state_t              state_reg, state_next;
        logic [K_DWIDTH-1:0] wcnt_reg, wcnt_next;
        logic [K_DWIDTH-1:0] pcnt_reg, pcnt_next;
        logic [K_DWIDTH-1:0] wlatch_reg, wlatch_next;
        logic [K_DWIDTH-1:0] width_reg, width_next;
        logic [K_DWIDTH-1:0] period_reg, period_next;
        logic                ovf_reg, ovf_next;
        logic                level_reg, level_next;
        logic                start_reg, start_next;
        logic                done_reg, done_next;

        logic                act, act_d, act_edge, inact_edge;
        logic                pol_chg, sat;
        logic [K_DWIDTH-1:0] wcnt_inc, pcnt_inc;

        // Both the current and delayed level use the registered polarity, so a
        // polarity flip by itself never looks like an edge.
        assign act        = sync2_reg ^ pol_reg;
        assign act_d      = sync_d_reg ^ pol_reg;
        assign act_edge   = act & ~act_d;
        assign inact_edge = ~act & act_d;
        assign pol_chg    = i_polarity[gi] ^ pol_reg;

        // A timebase pulse with the period counter already full means the
        // measurement cannot continue without wrapping.
        assign sat      = i_timebase & (pcnt_reg == CNT_MAX);
        assign wcnt_inc = (i_timebase && (wcnt_reg != CNT_MAX)) ? wcnt_reg + 1'b1 : wcnt_reg;
        assign pcnt_inc = (i_timebase && (pcnt_reg != CNT_MAX)) ? pcnt_reg + 1'b1 : pcnt_reg;

        // Channel state, counters, pin synchroniser and result registers.
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                sync1_reg  <= 1'b0;
                sync2_reg  <= 1'b0;
                sync_d_reg <= 1'b0;
                pol_reg    <= 1'b0;
                state_reg  <= ST_IDLE;
                wcnt_reg   <= '0;
                pcnt_reg   <= '0;
                wlatch_reg <= '0;
                width_reg  <= '0;
                period_reg <= '0;
                ovf_reg    <= 1'b0;
                level_reg  <= 1'b0;
                start_reg  <= 1'b0;
                done_reg   <= 1'b0;
            end else begin
                sync1_reg  <= i_pwm[gi];
                sync2_reg  <= sync1_reg;
                sync_d_reg <= sync2_reg;
                pol_reg    <= i_polarity[gi];
                state_reg  <= state_next;
                wcnt_reg   <= wcnt_next;
                pcnt_reg   <= pcnt_next;
                wlatch_reg <= wlatch_next;
                width_reg  <= width_next;
                period_reg <= period_next;
                ovf_reg    <= ovf_next;
                level_reg  <= level_next;
                start_reg  <= start_next;
                done_reg   <= done_next;
            end
        end

        // Next-state logic: edge tracking, counting and report generation.
        always_comb begin
            state_next  = state_reg;
            wcnt_next   = wcnt_reg;
            pcnt_next   = pcnt_reg;
            wlatch_next = wlatch_reg;
            width_next  = width_reg;
            period_next = period_reg;
            ovf_next    = ovf_reg;
            level_next  = level_reg;
            start_next  = 1'b0;
            done_next   = 1'b0;

            if (!i_enable[gi]) begin
                // Results are left untouched so software can still read them.
                state_next  = ST_IDLE;
                wcnt_next   = '0;
                pcnt_next   = '0;
                wlatch_next = '0;
            end else if ((state_reg != ST_IDLE) && pol_chg) begin
                // The running measurement refers to the old polarity; drop it.
                state_next  = ST_ARMED;
                wcnt_next   = '0;
                pcnt_next   = '0;
                wlatch_next = '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        state_next = ST_ARMED;
                    end
                    ST_ARMED: begin
                        if (act_edge) begin
                            state_next = ST_ACTIVE;
                            wcnt_next  = '0;
                            pcnt_next  = '0;
                            start_next = 1'b1;
                        end
                    end
                    ST_ACTIVE: begin
                        if (inact_edge) begin
                            // Timebase in the edge cycle still belongs to the active phase.
                            state_next  = ST_INACTIVE;
                            wlatch_next = wcnt_inc;
                            pcnt_next   = pcnt_inc;
                        end else if (sat) begin
                            state_next  = ST_ARMED;
                            width_next  = wcnt_reg;
                            period_next = CNT_MAX;
                            ovf_next    = 1'b1;
                            level_next  = sync2_reg;
                            done_next   = 1'b1;
                            wcnt_next   = '0;
                            pcnt_next   = '0;
                        end else begin
                            wcnt_next = wcnt_inc;
                            pcnt_next = pcnt_inc;
                        end
                    end
                    ST_INACTIVE: begin
                        if (act_edge) begin
                            // Report and immediately start the next period.
                            state_next  = ST_ACTIVE;
                            width_next  = wlatch_reg;
                            period_next = pcnt_inc;
                            ovf_next    = sat;
                            level_next  = sat & sync2_reg;
                            done_next   = 1'b1;
                            start_next  = 1'b1;
                            wcnt_next   = '0;
                            pcnt_next   = '0;
                        end else if (sat) begin
                            state_next  = ST_ARMED;
                            width_next  = wlatch_reg;
                            period_next = CNT_MAX;
                            ovf_next    = 1'b1;
                            level_next  = sync2_reg;
                            done_next   = 1'b1;
                            wcnt_next   = '0;
                            pcnt_next   = '0;
                        end else begin
                            pcnt_next = pcnt_inc;
                        end
                    end
                    default: begin
                        state_next = ST_IDLE;
                    end
                endcase
            end
        end

        assign o_capture_start[gi]                = start_reg;
        assign o_capture_done[gi]                 = done_reg;
        assign o_width[gi*K_DWIDTH +: K_DWIDTH]   = width_reg;
        assign o_period[gi*K_DWIDTH +: K_DWIDTH]  = period_reg;
        assign o_overflow[gi]                     = ovf_reg;
        assign o_level[gi]                        = level_reg;
    end

endmodule

// File: tb/tb_pwm_capture_mc.sv
// tb_pwm_capture_mc: directed bench for pwm_capture_mc with two 8-bit channels.
module tb_pwm_capture_mc;
    localparam int NCH = 2;
    localparam int DW  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              timebase = 1'b0;
    logic [NCH-1:0]    pwm = '0;
    logic [NCH-1:0]    pol = '0;
    logic [NCH-1:0]    en = '0;
    logic [NCH-1:0]    cap_start, cap_done, ovf, lvl;
    logic [NCH*DW-1:0] width_bus, period_bus;

    pwm_capture_mc #(.K_NCHAN(NCH), .K_DWIDTH(DW)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_timebase      (timebase),
        .i_pwm           (pwm),
        .i_polarity      (pol),
        .i_enable        (en),
        .o_capture_start (cap_start),
        .o_capture_done  (cap_done),
        .o_width         (width_bus),
        .o_period        (period_bus),
        .o_overflow      (ovf),
        .o_level         (lvl)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Waveform generator state: pwm[c] is high for hi[c] of every per[c] clocks.
    int hi[NCH]        = '{0, 0};
    int per[NCH]       = '{1, 1};
    int gcnt[NCH]      = '{0, 0};
    int last_rise[NCH] = '{0, 0};
    int tb_div         = 1;
    int tb_cnt         = 0;

    int start_cnt[NCH] = '{0, 0};
    int done_cnt[NCH]  = '{0, 0};

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic int wid(input int c);
        return int'(width_bus[c*DW +: DW]);
    endfunction

    function automatic int prd(input int c);
        return int'(period_bus[c*DW +: DW]);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int c, input int bound, input string tag, output int at);
        int k;
        at = -1;
        k  = 0;
        while (at < 0 && k < bound) begin
            @(negedge clk);
            #1;
            if (cap_done[c] === 1'b1) at = cyc;
            k++;
        end
        if (at < 0) check({tag, "_timeout"}, 0, 1);
        else $display("done  ch%0d cyc=%0d width=%0d period=%0d ovf=%0b level=%0b",
                      c, at, wid(c), prd(c), ovf[c], lvl[c]);
    endtask

    task automatic wait_start(input int c, input int bound, input string tag, output int at);
        int k;
        at = -1;
        k  = 0;
        while (at < 0 && k < bound) begin
            @(negedge clk);
            #1;
            if (cap_start[c] === 1'b1) at = cyc;
            k++;
        end
        if (at < 0) check({tag, "_timeout"}, 0, 1);
        else $display("start ch%0d cyc=%0d", c, at);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Drives pwm and timebase a little after each rising edge.
    initial forever begin
        logic nv;
        @(posedge clk);
        #2;
        for (int c = 0; c < NCH; c++) begin
            nv = (gcnt[c] < hi[c]);
            if (nv && !pwm[c]) last_rise[c] = cyc;
            pwm[c]  = nv;
            gcnt[c] = (gcnt[c] + 1) % per[c];
        end
        timebase = (tb_cnt == 0);
        tb_cnt   = (tb_cnt + 1) % tb_div;
    end

    // Counts output pulses, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
            if (cap_start[c] === 1'b1) start_cnt[c]++;
            if (cap_done[c] === 1'b1) done_cnt[c]++;
        end
    end

    initial begin
        int d1, d2, s1, sc, dc, st;

        // Reset state
        rst_n = 1'b0;
        tick(3);
        check("rst_width", int'(width_bus), 0);
        check("rst_period", int'(period_bus), 0);
        check("rst_done", int'(cap_done), 0);
        check("rst_start", int'(cap_start), 0);
        check("rst_ovf", int'(ovf), 0);

        // ch0 active-high 10/40, timebase every clock
        en = 2'b01; pol = 2'b00; tb_div = 1; tb_cnt = 0;
        hi[0] = 10; per[0] = 40; gcnt[0] = 0;
        rst_n = 1'b1;
        wait_done(0, 200, "t1_done1", d1);
        check("t1_width", wid(0), 10);
        check("t1_period", prd(0), 40);
        check("t1_ovf", int'(ovf[0]), 0);
        check("t1_level", int'(lvl[0]), 0);
        check("t1_start_with_done", int'(cap_start[0]), 1);
        check("t1_start_latency", d1 - last_rise[0], 3);
        wait_done(0, 60, "t1_done2", d2);
        check("t1_done_gap", d2 - d1, 40);
        check("t1_width2", wid(0), 10);

        // Active-low, timebase every 4th clock: low phase is measured
        tick(1);
        pol[0] = 1'b1; tb_div = 4; tb_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            wait_done(0, 150, "t2_done", d1);
            check("t2_width_7or8", int'(wid(0) == 7 || wid(0) == 8), 1);
            check("t2_period", prd(0), 10);
            check("t2_ovf", int'(ovf[0]), 0);
        end

        // Stuck-high input saturates
        tick(1);
        en[0] = 1'b0; pol[0] = 1'b0; tb_div = 1; tb_cnt = 0; hi[0] = 0;
        tick(5);
        en[0] = 1'b1;
        tick(5);
        st = start_cnt[0];
        gcnt[0] = 0; hi[0] = 100000; per[0] = 100001;
        wait_done(0, 400, "t3_done", d1);
        check("t3_starts", start_cnt[0] - st, 1);
        check("t3_width", wid(0), 255);
        check("t3_period", prd(0), 255);
        check("t3_ovf", int'(ovf[0]), 1);
        check("t3_level", int'(lvl[0]), 1);
        check("t3_no_start_on_sat", int'(cap_start[0]), 0);
        st = start_cnt[0];
        dc = done_cnt[0];
        tick(300);
        check("t3_no_restart", start_cnt[0] - st, 0);
        check("t3_no_more_done", done_cnt[0] - dc, 0);

        // Two channels with aligned rising edges: 10/40 and 5/20
        en = 2'b00; hi[0] = 0; hi[1] = 0;
        tick(5);
        en = 2'b11;
        tick(5);
        gcnt[0] = 0; gcnt[1] = 0;
        hi[0] = 10; per[0] = 40; hi[1] = 5; per[1] = 20;
        wait_done(0, 200, "t4_done0", d1);
        check("t4_ch1_coincident", int'(cap_done[1]), 1);
        check("t4_ch0_width", wid(0), 10);
        check("t4_ch0_period", prd(0), 40);
        check("t4_ch1_width", wid(1), 5);
        check("t4_ch1_period", prd(1), 20);
        check("t4_ovf", int'(ovf), 0);
        wait_done(1, 40, "t4_done1", d2);
        check("t4_ch1_gap", d2 - d1, 20);
        check("t4_ch0_quiet", int'(cap_done[0]), 0);

        // Disable ch0 mid-active, re-enable while the pin is still high
        wait_done(0, 50, "t5_align", d1);
        tick(2);
        en[0] = 1'b0;
        dc = done_cnt[0];
        tick(5);
        check("t5_hold_width", wid(0), 10);
        check("t5_hold_period", prd(0), 40);
        check("t5_no_done_off", done_cnt[0] - dc, 0);
        en[0] = 1'b1;
        wait_start(0, 60, "t5_start", s1);
        check("t5_start_next_rise", s1 - d1, 40);
        check("t5_start_latency", s1 - last_rise[0], 3);
        check("t5_no_done_yet", done_cnt[0] - dc, 0);

        // Reset during the inactive phase
        tick(20);
        rst_n = 1'b0;
        tick(1);
        check("t6_rst_width", int'(width_bus), 0);
        check("t6_rst_period", int'(period_bus), 0);
        check("t6_rst_start", int'(cap_start), 0);
        check("t6_rst_done", int'(cap_done), 0);
        check("t6_rst_ovf_lvl", int'({ovf, lvl}), 0);
        rst_n = 1'b1;
        st = start_cnt[0];
        wait_done(0, 150, "t6_done", d1);
        check("t6_two_edges", start_cnt[0] - st, 2);
        check("t6_width", wid(0), 10);
        check("t6_period", prd(0), 40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
